// File: rtl/cpu_sequencer_if.sv
// ---------------------------------------------------------------------------
// cpu_sequencer_if
//
// Purpose: bundles the program-load stream and the program-store write port
// of the CPU sequencer into one interface.
//
// Signals:
//   load_valid   - a program word is offered on load_data
//   load_data    - 3-bit program word
//   load_last    - the offered word is the final word of the program
//   load_ready   - the sequencer accepts the offered word this cycle
//   prog_wr_en   - registered write strobe towards the program store
//   prog_wr_addr - program-store address being written
//   prog_wr_data - program-store data being written
//
// Modports:
//   master - the loader side; drives the load stream, watches the write port
//   slave  - the sequencer side
// ---------------------------------------------------------------------------
interface cpu_sequencer_if;
    logic       load_valid;
    logic [2:0] load_data;
    logic       load_last;
    logic       load_ready;
    logic       prog_wr_en;
    logic [3:0] prog_wr_addr;
    logic [2:0] prog_wr_data;

    modport master (
        output load_valid, load_data, load_last,
        input  load_ready, prog_wr_en, prog_wr_addr, prog_wr_data
    );

    modport slave (
        input  load_valid, load_data, load_last,
        output load_ready, prog_wr_en, prog_wr_addr, prog_wr_data
    );
endinterface

// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
//
// Purpose: loads a program of up to 16 three-bit words into an external
// program store, then steps through it. The steps are fetch, execute and
// wait-for-done. A taken jump is opcode 3 with A non-zero. The program halts
// once the next instruction pointer plus 2 runs past the loaded length.
//
// Ports:
//   clk, rst_n     - clock (rising edge) and asynchronous active-low reset
//   ld             - load stream and program-store write port (slave side)
//   start          - begin execution at address 0 (honoured in IDLE/HALTED)
//   opcode,operand - instruction delivered by the fetch unit
//   a_is_zero      - register A equals zero
//   exec_done      - execute unit finished; only looked at in WAIT
//   instr_ptr      - current instruction pointer
//   halt           - low only in FETCH, so the fetch register captures then
//   exec_start     - one-cycle pulse telling the execute unit to run
//   halted, busy   - program ended / FSM in LOAD, FETCH, EXEC or WAIT
//   prog_len       - number of loaded words, 0..16
//   retired        - completed-instruction count, saturating
// ---------------------------------------------------------------------------
module cpu_sequencer (
    input  logic                 clk,
    input  logic                 rst_n,
    cpu_sequencer_if.slave       ld,
    input  logic                 start,
    input  logic [2:0]           opcode,
    input  logic [2:0]           operand,
    input  logic                 a_is_zero,
    input  logic                 exec_done,
    output logic [3:0]           instr_ptr,
    output logic                 halt,
    output logic                 exec_start,
    output logic                 halted,
    output logic                 busy,
    output logic [4:0]           prog_len,
    output logic [15:0]          retired
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FETCH,
        EXEC,
        WAIT,
        HALTED
    } state_t;

    state_t     state;
    logic [4:0] count;
    logic       load_accept;
    logic       jump_taken;
    logic [4:0] next_ip;
    logic [5:0] next_end;
    logic       past_end;

    // The store holds 16 words. While loading, the sequencer stops accepting
    // once it holds 16. It accepts freely in IDLE and HALTED, where a new
    // word restarts the load from address 0.
    assign ld.load_ready = (state == IDLE) || (state == HALTED) ||
                           ((state == LOAD) && (count < 5'd16));
    assign load_accept   = ld.load_valid && ld.load_ready;

    // The loaded word count is the program length.
    assign prog_len = count;

    // The following outputs are decoded straight from the state register.
    // They therefore change only on a clock edge or on reset.
    assign halt       = (state != FETCH);
    assign exec_start = (state == EXEC);
    assign busy       = (state == LOAD) || (state == FETCH) ||
                        (state == EXEC) || (state == WAIT);

    // Next instruction pointer. It is kept 5 bits wide so that
    // instr_ptr + 2 cannot wrap. The end-of-program test is widened to
    // 6 bits for the same reason.
    assign jump_taken = (opcode == 3'd3) && !a_is_zero;
    assign next_ip    = jump_taken ? {2'b00, operand} : ({1'b0, instr_ptr} + 5'd2);
    assign next_end   = {1'b0, next_ip} + 6'd2;
    assign past_end   = next_end > {1'b0, count};

    // Main sequencer FSM.
    // A load word always beats a start requested in the same cycle. In LOAD,
    // a full store (count 16) spends one cycle with load_ready low before the
    // FSM returns to IDLE. This keeps a 17th word from restarting the load.
    // If the very first word is already marked last, the FSM goes straight
    // back to IDLE. It does not sit in LOAD waiting for words that will never
    // come.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            count           <= 5'd0;
            instr_ptr       <= 4'd0;
            retired         <= 16'd0;
            halted          <= 1'b0;
            ld.prog_wr_en   <= 1'b0;
            ld.prog_wr_addr <= 4'd0;
            ld.prog_wr_data <= 3'd0;
        end else begin
            ld.prog_wr_en <= 1'b0;
            case (state)
                IDLE, HALTED: begin
                    if (load_accept) begin
                        ld.prog_wr_en   <= 1'b1;
                        ld.prog_wr_addr <= 4'd0;
                        ld.prog_wr_data <= ld.load_data;
                        count           <= 5'd1;
                        state           <= ld.load_last ? IDLE : LOAD;
                    end else if (start && (count >= 5'd2)) begin
                        instr_ptr <= 4'd0;
                        retired   <= 16'd0;
                        halted    <= 1'b0;
                        state     <= FETCH;
                    end
                end
                LOAD: begin
                    if (count == 5'd16) begin
                        state <= IDLE;
                    end else if (load_accept) begin
                        ld.prog_wr_en   <= 1'b1;
                        ld.prog_wr_addr <= count[3:0];
                        ld.prog_wr_data <= ld.load_data;
                        count           <= count + 5'd1;
                        if (ld.load_last) begin
                            state <= IDLE;
                        end
                    end
                end
                FETCH: begin
                    state <= EXEC;
                end
                EXEC: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (exec_done) begin
                        if (retired != 16'hFFFF) begin
                            retired <= retired + 16'd1;
                        end
                        if (past_end) begin
                            halted <= 1'b1;
                            state  <= HALTED;
                        end else begin
                            instr_ptr <= next_ip[3:0];
                            state     <= FETCH;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-002 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 Port: load_valid / load_data / load_last  input  1/3/1  program-word load stream; load_last marks the final word.
REQ-004 Port: load_ready  output  1  sequencer accepts the current load word.
REQ-005 Port: prog_wr_en / prog_wr_addr / prog_wr_data  output  1/4/3  registered write port to the program store.
REQ-006 Port: start  input  1  begin execution at address 0.
REQ-007 Port: opcode / operand  input  3/3  fetched instruction from the fetch unit.
REQ-008 Port: a_is_zero  input  1  register A equals zero.
REQ-009 Port: exec_done  input  1  execute unit finished the current instruction.
REQ-010 Port: instr_ptr  output  4  current instruction pointer.
REQ-011 Port: halt  output  1  freezes the fetch register when 1.
REQ-012 Port: exec_start  output  1  single-cycle pulse telling the execute unit to run.
REQ-013 Port: halted / busy  output  1/1  program ended; FSM is in LOAD, FETCH, EXEC or WAIT.
REQ-014 Port: prog_len  output  5  number of loaded words, 0..16.
REQ-015 Port: retired  output  16  count of completed instructions.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, FETCH, EXEC, WAIT and HALTED.
REQ-017 load_ready SHALL be 1 in IDLE, in HALTED, and in LOAD while word count < 16; it is 0 otherwise.
REQ-018 An accepted word in IDLE/HALTED SHALL clear the count, write address 0, set count=1 and enter LOAD.
REQ-019 Each accepted word SHALL produce prog_wr_en=1 one cycle later, with addr=count and data=load_data, then count+1.
REQ-020 LOAD SHALL return to IDLE after accepting a word with load_last=1, or when count reaches 16; prog_len SHALL equal count.
REQ-021 start SHALL be honoured only in IDLE/HALTED with prog_len>=2 and no accepted load that cycle: instr_ptr=0, retired=0, halted=0, go to FETCH; otherwise it is ignored.
REQ-022 halt SHALL be 0 only in FETCH (exactly one cycle), so the fetch register captures opcode/operand for instr_ptr.
REQ-023 FETCH SHALL always go to EXEC; EXEC SHALL assert exec_start for one cycle and always go to WAIT.
REQ-024 exec_done SHALL be sampled only in WAIT; exec_done in any other state SHALL be ignored.
REQ-025 On exec_done in WAIT, next_ip (5-bit) SHALL be operand when opcode==3 and a_is_zero==0, else instr_ptr+2.
REQ-026 On exec_done in WAIT, retired SHALL increment, saturating at 16'hFFFF.
REQ-027 If next_ip+2 > prog_len (6-bit compare), the FSM SHALL enter HALTED with halted=1 and instr_ptr unchanged.
REQ-028 If REQ-027 does not apply, instr_ptr SHALL take next_ip[3:0] and the FSM SHALL go to FETCH.
REQ-029 start and load_valid SHALL be ignored in FETCH, EXEC and WAIT.
REQ-030 The FSM SHALL stay in WAIT indefinitely until exec_done arrives; there is no timeout.

Reset
REQ-031 On rst_n=0, all outputs and state SHALL clear immediately, regardless of state: state=IDLE, instr_ptr=0, prog_len=0, retired=0, halt=1, halted=0, busy=0, exec_start=0, prog_wr_en=0, count=0.
REQ-032 Program-store contents are outside this block and SHALL be left unaffected by reset.

Verification
REQ-033 Load 0,1,5,3 (last on the 4th word) -> writes to addresses 0..3, prog_len=4.
REQ-034 Then start; exec_done with opcode 0 -> instr_ptr=2; exec_done with opcode 5 -> HALTED, retired=2, instr_ptr=2.
REQ-035 Jump: opcode=3, operand=0, a_is_zero=0 -> instr_ptr=0, back to FETCH; repeat with a_is_zero=1 -> instr_ptr=2.
REQ-036 Load boundary: 17 words, no last -> 16 writes, load_ready=0 on the 17th cycle, state IDLE, prog_len=16.
REQ-037 Jump past end: prog_len=8, opcode=3, operand=7, a_is_zero=0 -> HALTED; start with prog_len=1 -> ignored, halted and busy unchanged.
REQ-038 Mid-run reset: rst_n=0 in WAIT -> all REQ-031 values within the same cycle; a later exec_done is ignored.
